asic_cfg_responder: RTL and testbench

- Synchronous, oversampled SPI-style configuration responder: the ASIC-side end of the bridge's serial config link.
- Receives serial clock, MOSI and select from the bridge master and deserialises fixed-length config frames.
- Commits each complete frame to a parallel config register.
- Returns the previously committed frame on MISO so the master can run its XOR readback check.
- Used as the ASIC model in bridge simulations and as a synthesizable slave for loopback tests.

---
 rtl/asic_bridge_pkg.sv | 12 +
 rtl/bridge_sync_edge.sv | 33 +++
 rtl/asic_cfg_responder.sv | 150 +++++++++++++++
 tb/tb_asic_cfg_responder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/asic_bridge_pkg.sv
// Shared types and constants for the ASIC-side config link responder.
package asic_bridge_pkg;

    localparam int unsigned CFG_FRAME_BITS = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        COMMIT
    } cfg_rsp_state_t;

endpackage

// File: rtl/bridge_sync_edge.sv
// Two-flop synchronizer with a third stage so level, rise and fall all share one latency.
module bridge_sync_edge (
    input  logic CLK,
    input  logic RST,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q, sync_q, level_q, rise_q, fall_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            meta_q  <= din;
            sync_q  <= meta_q;
            level_q <= sync_q;
            rise_q  <= sync_q & ~level_q;
            fall_q  <= ~sync_q & level_q;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/asic_cfg_responder.sv
// Oversampled mode-0 SPI config slave: deserialises frames, commits good ones, replays the
// previously committed frame on MISO.
module asic_cfg_responder
    import asic_bridge_pkg::*;
#(
    parameter int unsigned             FRAME_BITS     = CFG_FRAME_BITS,
    parameter bit                      SEL_ACTIVE_LOW = 1'b1,
    parameter logic [FRAME_BITS-1:0]   CFG_RESET      = '0,
    parameter int unsigned             CNT_W          = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  sck_input,
    input  logic                  mosi_input,
    input  logic                  sel_input,
    output logic                  miso_output,
    output logic [FRAME_BITS-1:0] cfg_word,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic [CNT_W-1:0]      frame_cnt,
    output logic                  busy
);

    localparam int unsigned BCW = $clog2(FRAME_BITS + 2);

    logic sck_level_unused, sck_rise, sck_fall;
    logic sel_lvl, sel_rise, sel_fall;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;
    logic sel_raw;

    // Normalise select to active-high before sync so reset clears it to inactive.
    assign sel_raw = SEL_ACTIVE_LOW ? ~sel_input : sel_input;

    bridge_sync_edge u_sync_sck (
        .CLK   (CLK),
        .RST   (RST),
        .din   (sck_input),
        .level (sck_level_unused),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    bridge_sync_edge u_sync_sel (
        .CLK   (CLK),
        .RST   (RST),
        .din   (sel_raw),
        .level (sel_lvl),
        .rise  (sel_rise),
        .fall  (sel_fall)
    );

    bridge_sync_edge u_sync_mosi (
        .CLK   (CLK),
        .RST   (RST),
        .din   (mosi_input),
        .level (mosi_lvl),
        .rise  (mosi_rise_unused),
        .fall  (mosi_fall_unused)
    );

    cfg_rsp_state_t        state_q, state_d;
    logic [FRAME_BITS-1:0] rx_shift_q, rb_shift_q, readback_q, cfg_q;
    logic [BCW-1:0]        bit_cnt_q;
    logic [CNT_W-1:0]      frame_cnt_q;
    logic                  miso_q, valid_q, err_q;
    logic                  load, commit_good, commit_bad;
    logic [FRAME_BITS-1:0] rb_load_val;

    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        commit_good = 1'b0;
        commit_bad  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sel_rise) begin
                    state_d = ACTIVE;
                    load    = 1'b1;
                end
            end
            ACTIVE: begin
                if (sel_fall) state_d = COMMIT;
            end
            COMMIT: begin
                commit_good = (bit_cnt_q == BCW'(FRAME_BITS));
                commit_bad  = !commit_good && (bit_cnt_q != '0);
                if (sel_lvl) begin
                    state_d = ACTIVE;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A back-to-back frame must replay the frame being committed this cycle.
        rb_load_val = commit_good ? rx_shift_q : readback_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            rx_shift_q  <= '0;
            rb_shift_q  <= '0;
            readback_q  <= CFG_RESET;
            cfg_q       <= CFG_RESET;
            bit_cnt_q   <= '0;
            frame_cnt_q <= '0;
            miso_q      <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= commit_good;
            err_q   <= commit_bad;
            if (commit_good) begin
                cfg_q       <= rx_shift_q;
                readback_q  <= rx_shift_q;
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
            if (load) begin
                rb_shift_q <= rb_load_val;
                miso_q     <= rb_load_val[FRAME_BITS-1];
                bit_cnt_q  <= '0;
            end else if (state_q == ACTIVE) begin
                if (!sel_fall) begin
                    if (sck_rise) begin
                        rx_shift_q <= {rx_shift_q[FRAME_BITS-2:0], mosi_lvl};
                        if (bit_cnt_q != BCW'(FRAME_BITS + 1)) bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                    if (sck_fall) begin
                        rb_shift_q <= {rb_shift_q[FRAME_BITS-2:0], 1'b0};
                        miso_q     <= rb_shift_q[FRAME_BITS-2];
                    end
                end
            end else begin
                miso_q <= 1'b0;
                if (state_q == IDLE) bit_cnt_q <= '0;
            end
        end
    end

    assign miso_output = miso_q;
    assign cfg_word    = cfg_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign frame_cnt   = frame_cnt_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_asic_cfg_responder.sv
// Directed bench: frames driven at SCK = CLK/16 into active-low and active-high select variants.
module tb_asic_cfg_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sck = 1'b0;
    logic        mosi = 1'b0;
    logic        sel_act = 1'b0;
    logic        sel_n, sel_h;

    logic        miso_l, valid_l, err_l, busy_l;
    logic [31:0] cfg_l;
    logic [15:0] cnt_l;
    logic        miso_h, valid_h, err_h, busy_h;
    logic [31:0] cfg_h;
    logic [15:0] cnt_h;

    int checks = 0;
    int failures = 0;
    int nv_l = 0, ne_l = 0, nv_h = 0, ne_h = 0;

    assign sel_n = ~sel_act;
    assign sel_h = sel_act;

    always #5 clk = ~clk;

    asic_cfg_responder #(
        .SEL_ACTIVE_LOW (1'b1)
    ) dut_l (
        .CLK         (clk),
        .RST         (rst),
        .sck_input   (sck),
        .mosi_input  (mosi),
        .sel_input   (sel_n),
        .miso_output (miso_l),
        .cfg_word    (cfg_l),
        .frame_valid (valid_l),
        .frame_err   (err_l),
        .frame_cnt   (cnt_l),
        .busy        (busy_l)
    );

    asic_cfg_responder #(
        .SEL_ACTIVE_LOW (1'b0)
    ) dut_h (
        .CLK         (clk),
        .RST         (rst),
        .sck_input   (sck),
        .mosi_input  (mosi),
        .sel_input   (sel_h),
        .miso_output (miso_h),
        .cfg_word    (cfg_h),
        .frame_valid (valid_h),
        .frame_err   (err_h),
        .frame_cnt   (cnt_h),
        .busy        (busy_h)
    );

    always @(negedge clk) begin
        if (valid_l) nv_l <= nv_l + 1;
        if (err_l)   ne_l <= ne_l + 1;
        if (valid_h) nv_h <= nv_h + 1;
        if (err_h)   ne_h <= ne_h + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // MSB-first, 8 CLK per SCK phase; MISO captured as the master would at SCK rise.
    task automatic send_bits(input logic [63:0] data, input int nbits,
                             output logic [63:0] cap_l, output logic [63:0] cap_h);
        cap_l = '0;
        cap_h = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = data[i];
            wait_neg(8);
            cap_l = {cap_l[62:0], miso_l};
            cap_h = {cap_h[62:0], miso_h};
            sck = 1'b1;
            wait_neg(8);
            sck = 1'b0;
        end
        mosi = 1'b0;
    endtask

    task automatic run_frame(input logic [63:0] data, input int nbits,
                             output logic [63:0] cap_l, output logic [63:0] cap_h,
                             output int dv_l, output int de_l, output int dv_h, output int de_h);
        int v0l, e0l, v0h, e0h;
        v0l = nv_l; e0l = ne_l; v0h = nv_h; e0h = ne_h;
        @(negedge clk);
        sel_act = 1'b1;
        wait_neg(8);
        send_bits(data, nbits, cap_l, cap_h);
        wait_neg(8);
        sel_act = 1'b0;
        wait_neg(12);
        dv_l = nv_l - v0l; de_l = ne_l - e0l;
        dv_h = nv_h - v0h; de_h = ne_h - e0h;
    endtask

    typedef struct {
        logic [63:0] data;
        int          nbits;
        int          exp_valid;
        int          exp_err;
        logic [31:0] exp_cfg;
        logic [15:0] exp_cnt;
        logic [63:0] exp_miso;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [63:0] cl, ch, dummy_l, dummy_h;
        int dvl, del, dvh, deh, v0l, e0l;

        vecs[0] = '{64'hA5A53C3C,    32, 1, 0, 32'hA5A53C3C, 16'd1, 64'h0};
        vecs[1] = '{64'h12345678,    32, 1, 0, 32'h12345678, 16'd2, 64'hA5A53C3C};
        vecs[2] = '{64'h7FFFFFFF,    31, 0, 1, 32'h12345678, 16'd2, 64'h091A2B3C};
        vecs[3] = '{64'h1FFFFFFFF,   33, 0, 1, 32'h12345678, 16'd2, 64'h2468ACF0};
        vecs[4] = '{64'h0,            0, 0, 0, 32'h12345678, 16'd2, 64'h0};
        vecs[5] = '{64'hCAFEF00D,    32, 1, 0, 32'hCAFEF00D, 16'd3, 64'h12345678};

        wait_neg(4);
        rst = 1'b0;
        @(negedge clk);
        check("reset_cfg", {32'h0, cfg_l}, 64'h0);
        check("reset_cnt", {48'h0, cnt_l}, 64'h0);
        check("reset_busy_miso", {62'h0, busy_l, miso_l}, 64'h0);
        check("reset_pulses", {60'h0, valid_l, err_l, valid_h, err_h}, 64'h0);

        for (int k = 0; k < 6; k++) begin
            run_frame(vecs[k].data, vecs[k].nbits, cl, ch, dvl, del, dvh, deh);
            check($sformatf("v%0d_valid_l", k), 64'(dvl), 64'(vecs[k].exp_valid));
            check($sformatf("v%0d_err_l", k), 64'(del), 64'(vecs[k].exp_err));
            check($sformatf("v%0d_cfg_l", k), {32'h0, cfg_l}, {32'h0, vecs[k].exp_cfg});
            check($sformatf("v%0d_cnt_l", k), {48'h0, cnt_l}, {48'h0, vecs[k].exp_cnt});
            check($sformatf("v%0d_miso_l", k), cl, vecs[k].exp_miso);
            check($sformatf("v%0d_busy_l", k), {63'h0, busy_l}, 64'h0);
            check($sformatf("v%0d_valid_h", k), 64'(dvh), 64'(vecs[k].exp_valid));
            check($sformatf("v%0d_err_h", k), 64'(deh), 64'(vecs[k].exp_err));
            check($sformatf("v%0d_cfg_h", k), {32'h0, cfg_h}, {32'h0, vecs[k].exp_cfg});
            check($sformatf("v%0d_cnt_h", k), {48'h0, cnt_h}, {48'h0, vecs[k].exp_cnt});
            check($sformatf("v%0d_miso_h", k), ch, vecs[k].exp_miso);
        end

        // Select toggle with no SCK: busy while selected, then nothing committed.
        @(negedge clk);
        sel_act = 1'b1;
        wait_neg(8);
        check("nosck_busy_high", {62'h0, busy_l, busy_h}, 64'h3);
        sel_act = 1'b0;
        wait_neg(12);
        check("nosck_busy_low", {62'h0, busy_l, busy_h}, 64'h0);

        // Exact pulse timing: frame_valid visible only in the 5th sample after sel release.
        v0l = nv_l; e0l = ne_l;
        @(negedge clk);
        sel_act = 1'b1;
        wait_neg(8);
        send_bits(64'h0F0F0F0F, 32, dummy_l, dummy_h);
        wait_neg(8);
        sel_act = 1'b0;
        wait_neg(4);
        check("t4_valid_busy", {62'h0, valid_l, busy_l}, 64'h1);
        @(negedge clk);
        check("t5_valid_busy", {62'h0, valid_l, busy_l}, 64'h2);
        check("t5_cfg", {32'h0, cfg_l}, 64'h0F0F0F0F);
        @(negedge clk);
        check("t6_valid", {63'h0, valid_l}, 64'h0);
        check("t_cnt", {48'h0, cnt_l}, 64'd4);
        check("t_miso", dummy_l, 64'hCAFEF00D);
        wait_neg(8);
        check("t_pulses", 64'(nv_l - v0l), 64'd1);
        check("t_err", 64'(ne_l - e0l), 64'd0);

        // Reset mid-frame after 16 bits of 0xDEADBEEF.
        @(negedge clk);
        sel_act = 1'b1;
        wait_neg(8);
        send_bits(64'hDEAD, 16, dummy_l, dummy_h);
        wait_neg(4);
        v0l = nv_l; e0l = ne_l;
        rst = 1'b1;
        sel_act = 1'b0;
        @(negedge clk);
        check("rst_next_cfg", {32'h0, cfg_l}, 64'h0);
        check("rst_next_cnt_busy", {47'h0, cnt_l, busy_l}, 64'h0);
        wait_neg(2);
        rst = 1'b0;
        wait_neg(12);
        check("rst_no_pulse", 64'((nv_l - v0l) + (ne_l - e0l)), 64'd0);
        check("rst_state", {30'h0, cfg_l, busy_l, miso_l}, 64'h0);

        run_frame(64'hFFFF0000, 32, cl, ch, dvl, del, dvh, deh);
        check("post_rst_valid", 64'(dvl + dvh), 64'd2);
        check("post_rst_err", 64'(del + deh), 64'd0);
        check("post_rst_cfg", {cfg_l, cfg_h}, {32'hFFFF0000, 32'hFFFF0000});
        check("post_rst_cnt", {32'h0, cnt_l, cnt_h}, {32'h0, 16'd1, 16'd1});
        check("post_rst_miso", cl, 64'h0);

        run_frame(64'h00000001, 32, cl, ch, dvl, del, dvh, deh);
        check("rb_after_rst_l", cl, 64'hFFFF0000);
        check("rb_after_rst_h", ch, 64'hFFFF0000);
        check("final_cfg_cnt", {16'h0, cfg_l, cnt_l}, {16'h0, 32'h00000001, 16'd2});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
